ula_arbitro: RTL and testbench

Shares the single 8-bit ALU between two requesters: requester 0 is the main datapath and requester 1 is the address/branch unit. Uses a request/accept handshake with round-robin priority on contention. Latches the winning operands and operation, drives the ALU combinationally from those registers, then returns the registered result and zero flag with a valid/ready handshake. Sits between the requesters and the ALU instance, which it owns exclusively.

---
 rtl/ula_arbitro.sv | 149 ++++++++++++++
 tb/tb_ula_arbitro.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_arbitro.sv
// Arbiter that shares one combinational ALU between two requesters with round-robin priority.
// Operands are latched on grant, and the result is returned through a valid/ready handshake.
module ula_arbitro #(
    parameter int LARGURA = 8,
    parameter int OP_W    = 3
) (
    input  logic               clock,
    input  logic               reset,

    input  logic               req0,
    input  logic [LARGURA-1:0] op0_a,
    input  logic [LARGURA-1:0] op0_b,
    input  logic [OP_W-1:0]    sinal0,
    output logic               aceito0,
    output logic               valido0,
    input  logic               pronto0,
    output logic [LARGURA-1:0] resultado0,
    output logic               zero0,

    input  logic               req1,
    input  logic [LARGURA-1:0] op1_a,
    input  logic [LARGURA-1:0] op1_b,
    input  logic [OP_W-1:0]    sinal1,
    output logic               aceito1,
    output logic               valido1,
    input  logic               pronto1,
    output logic [LARGURA-1:0] resultado1,
    output logic               zero1,

    output logic [LARGURA-1:0] alu_entrada1,
    output logic [LARGURA-1:0] alu_entrada2,
    output logic [OP_W-1:0]    alu_sinal,
    input  logic [LARGURA-1:0] alu_saida,
    input  logic               alu_zero,

    output logic               ocupado
);

    typedef enum logic [1:0] {StOcioso, StExecuta, StResposta} estado_t;

    estado_t            estado_q, estado_d;
    logic               prioridade_q, prioridade_d;
    logic               concedido_q, concedido_d;
    logic [LARGURA-1:0] entrada1_q, entrada1_d;
    logic [LARGURA-1:0] entrada2_q, entrada2_d;
    logic [OP_W-1:0]    sinal_q, sinal_d;
    logic [1:0]         aceito_q, aceito_d;
    logic [1:0]         valido_q, valido_d;
    logic [1:0]         zero_q, zero_d;
    logic [LARGURA-1:0] resultado0_q, resultado0_d;
    logic [LARGURA-1:0] resultado1_q, resultado1_d;

    logic               vencedor;
    logic               pronto_sel;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q     <= StOcioso;
            prioridade_q <= 1'b0;
            concedido_q  <= 1'b0;
            entrada1_q   <= '0;
            entrada2_q   <= '0;
            sinal_q      <= '0;
            aceito_q     <= '0;
            valido_q     <= '0;
            zero_q       <= '0;
            resultado0_q <= '0;
            resultado1_q <= '0;
        end else begin
            estado_q     <= estado_d;
            prioridade_q <= prioridade_d;
            concedido_q  <= concedido_d;
            entrada1_q   <= entrada1_d;
            entrada2_q   <= entrada2_d;
            sinal_q      <= sinal_d;
            aceito_q     <= aceito_d;
            valido_q     <= valido_d;
            zero_q       <= zero_d;
            resultado0_q <= resultado0_d;
            resultado1_q <= resultado1_d;
        end
    end

    always_comb begin
        estado_d     = estado_q;
        prioridade_d = prioridade_q;
        concedido_d  = concedido_q;
        entrada1_d   = entrada1_q;
        entrada2_d   = entrada2_q;
        sinal_d      = sinal_q;
        aceito_d     = 2'b00;
        valido_d     = valido_q;
        zero_d       = zero_q;
        resultado0_d = resultado0_q;
        resultado1_d = resultado1_q;

        // A lone requester wins outright; priority only breaks ties.
        vencedor   = (req0 && req1) ? prioridade_q : req1;
        pronto_sel = concedido_q ? pronto1 : pronto0;

        unique case (estado_q)
            StOcioso: begin
                if (req0 || req1) begin
                    concedido_d = vencedor;
                    entrada1_d  = vencedor ? op1_a  : op0_a;
                    entrada2_d  = vencedor ? op1_b  : op0_b;
                    sinal_d     = vencedor ? sinal1 : sinal0;
                    aceito_d    = vencedor ? 2'b10  : 2'b01;
                    estado_d    = StExecuta;
                end
            end
            StExecuta: begin
                if (concedido_q) begin
                    resultado1_d = alu_saida;
                    zero_d[1]    = alu_zero;
                    valido_d     = 2'b10;
                end else begin
                    resultado0_d = alu_saida;
                    zero_d[0]    = alu_zero;
                    valido_d     = 2'b01;
                end
                estado_d = StResposta;
            end
            StResposta: begin
                if (pronto_sel && valido_q[concedido_q]) begin
                    valido_d     = 2'b00;
                    prioridade_d = ~concedido_q;
                    estado_d     = StOcioso;
                end
            end
            default: estado_d = StOcioso;
        endcase
    end

    assign alu_entrada1 = entrada1_q;
    assign alu_entrada2 = entrada2_q;
    assign alu_sinal    = sinal_q;

    assign aceito0    = aceito_q[0];
    assign aceito1    = aceito_q[1];
    assign valido0    = valido_q[0];
    assign valido1    = valido_q[1];
    assign zero0      = zero_q[0];
    assign zero1      = zero_q[1];
    assign resultado0 = resultado0_q;
    assign resultado1 = resultado1_q;
    assign ocupado    = (estado_q != StOcioso);

endmodule

// File: tb/tb_ula_arbitro.sv
// Self-checking bench for ula_arbitro: directed scenarios plus randomized transactions
// compared against a transaction-level model with its own ALU function.
module tb_ula_arbitro;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req[2];
    logic [7:0] op_a[2];
    logic [7:0] op_b[2];
    logic [2:0] sinal[2];
    logic       pronto[2];
    logic       aceito[2];
    logic       valido[2];
    logic [7:0] res_o[2];
    logic       zero_o[2];
    logic [7:0] alu_entrada1, alu_entrada2, alu_saida;
    logic [2:0] alu_sinal;
    logic       alu_zero;
    logic       ocupado;

    int n_checks = 0;
    int n_fail   = 0;
    int prio_m   = 0;
    logic [7:0] res_m[2];
    logic       zero_m[2];

    always #5 clock = ~clock;

    ula_arbitro #(.LARGURA(8), .OP_W(3)) dut (
        .clock(clock), .reset(reset),
        .req0(req[0]), .op0_a(op_a[0]), .op0_b(op_b[0]), .sinal0(sinal[0]),
        .aceito0(aceito[0]), .valido0(valido[0]), .pronto0(pronto[0]),
        .resultado0(res_o[0]), .zero0(zero_o[0]),
        .req1(req[1]), .op1_a(op_a[1]), .op1_b(op_b[1]), .sinal1(sinal[1]),
        .aceito1(aceito[1]), .valido1(valido[1]), .pronto1(pronto[1]),
        .resultado1(res_o[1]), .zero1(zero_o[1]),
        .alu_entrada1(alu_entrada1), .alu_entrada2(alu_entrada2), .alu_sinal(alu_sinal),
        .alu_saida(alu_saida), .alu_zero(alu_zero),
        .ocupado(ocupado)
    );

    // Reference ALU, returns {zero, result}
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
        logic [7:0] r;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a + b;
            3'd3:    r = a - b;
            3'd4:    r = (a < b) ? 8'd1 : 8'd0;
            default: r = 8'd0;
        endcase
        return {(r == 8'd0), r};
    endfunction

    assign {alu_zero, alu_saida} = alu_f(alu_entrada1, alu_entrada2, alu_sinal);

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input int w, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op);
        op_a[w] = a; op_b[w] = b; sinal[w] = op;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            req[i] = 0; pronto[i] = 0; set_op(i, 8'h00, 8'h00, 3'd0);
        end
        reset = 1;
        tick(); tick();
        n_checks++;
        if ({aceito[0], aceito[1], valido[0], valido[1], ocupado, zero_o[0], zero_o[1],
             res_o[0], res_o[1], alu_entrada1, alu_entrada2, alu_sinal} !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_state: got res0=%0d res1=%0d oc=%b ac=%b%b va=%b%b want all zero",
                     res_o[0], res_o[1], ocupado, aceito[1], aceito[0], valido[1], valido[0]);
        end
        reset = 0;
        prio_m = 0;
        tick();
        n_checks++;
        if (ocupado !== 1'b0) begin
            n_fail++; $display("FAIL idle_no_req: ocupado got %b want 0", ocupado);
        end
    endtask

    task automatic test_add();
        req[0] = 1; set_op(0, 8'd200, 8'd100, 3'd2);
        tick();
        req[0] = 0;
        n_checks++;
        if ({aceito[1], aceito[0], valido[1], valido[0], ocupado} !== 5'b01001) begin
            n_fail++; $display("FAIL add_grant: got ac=%b%b va=%b%b oc=%b want ac=01 va=00 oc=1",
                               aceito[1], aceito[0], valido[1], valido[0], ocupado);
        end
        tick();
        n_checks++;
        if ({aceito[0], valido[0], ocupado, res_o[0], zero_o[0]} !== {3'b011, 8'd44, 1'b0}) begin
            n_fail++; $display("FAIL add_result: got ac=%b va=%b oc=%b res=%0d z=%b want 0 1 1 44 0",
                               aceito[0], valido[0], ocupado, res_o[0], zero_o[0]);
        end
        pronto[0] = 1;
        tick();
        pronto[0] = 0;
        n_checks++;
        if ({valido[0], ocupado} !== 2'b00) begin
            n_fail++; $display("FAIL add_done: got va=%b oc=%b want 0 0", valido[0], ocupado);
        end
        prio_m = 1;
    endtask

    task automatic test_back_to_back();
        req[1] = 1; pronto[1] = 1; set_op(1, 8'd5, 8'd5, 3'd3);
        tick();
        n_checks++;
        if (aceito[1] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_grant1: aceito1 got %b want 1", aceito[1]);
        end
        set_op(1, 8'd3, 8'd7, 3'd3);
        tick();
        n_checks++;
        if ({valido[1], res_o[1], zero_o[1]} !== {1'b1, 8'd0, 1'b1}) begin
            n_fail++; $display("FAIL b2b_res1: got va=%b res=%0d z=%b want 1 0 1",
                               valido[1], res_o[1], zero_o[1]);
        end
        tick();
        n_checks++;
        if ({valido[1], aceito[1]} !== 2'b00) begin
            n_fail++; $display("FAIL b2b_gap: got va=%b ac=%b want 0 0", valido[1], aceito[1]);
        end
        tick();
        req[1] = 0;
        n_checks++;
        if (aceito[1] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_grant2: aceito1 got %b want 1", aceito[1]);
        end
        tick();
        n_checks++;
        if ({valido[1], res_o[1], zero_o[1]} !== {1'b1, 8'd252, 1'b0}) begin
            n_fail++; $display("FAIL b2b_res2: got va=%b res=%0d z=%b want 1 252 0",
                               valido[1], res_o[1], zero_o[1]);
        end
        tick();
        pronto[1] = 0;
        prio_m = 0;
    endtask

    task automatic test_contention();
        reset = 1;
        req[0] = 1; req[1] = 1; pronto[0] = 1; pronto[1] = 1;
        set_op(0, 8'd1, 8'd1, 3'd2);
        set_op(1, 8'hF0, 8'h0F, 3'd1);
        tick();
        reset = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if ({aceito[1], aceito[0]} !== ((k % 2) ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL contention_grant%0d: got %b%b want %0d", k,
                                   aceito[1], aceito[0], k % 2);
            end
            tick();
            tick();
        end
        n_checks++;
        if ({res_o[0], res_o[1]} !== {8'd2, 8'hFF}) begin
            n_fail++; $display("FAIL contention_res: got %0h %0h want 2 ff", res_o[0], res_o[1]);
        end
        req[0] = 0; req[1] = 0; pronto[0] = 0; pronto[1] = 0;
        tick();
        prio_m = 0;
    endtask

    task automatic test_hold();
        req[0] = 1; set_op(0, 8'd3, 8'd7, 3'd4);
        tick();
        req[0] = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            pronto[1] = 1;
            tick();
            n_checks++;
            if ({valido[0], ocupado, res_o[0], zero_o[0]} !== {2'b11, 8'd1, 1'b0}) begin
                n_fail++; $display("FAIL hold_%0d: got va=%b oc=%b res=%0d z=%b want 1 1 1 0",
                                   i, valido[0], ocupado, res_o[0], zero_o[0]);
            end
        end
        pronto[1] = 0; pronto[0] = 1;
        tick();
        pronto[0] = 0;
        n_checks++;
        if ({valido[0], ocupado} !== 2'b00) begin
            n_fail++; $display("FAIL hold_release: got va=%b oc=%b want 0 0", valido[0], ocupado);
        end
        prio_m = 1;
    endtask

    task automatic test_reset_mid();
        req[0] = 1; req[1] = 1;
        set_op(0, 8'd10, 8'd20, 3'd2);
        set_op(1, 8'h0C, 8'h30, 3'd1);
        tick();
        n_checks++;
        if ({aceito[1], aceito[0]} !== 2'b10) begin
            n_fail++; $display("FAIL mid_first_grant: got %b%b want 10", aceito[1], aceito[0]);
        end
        reset = 1;
        #1;
        n_checks++;
        if ({aceito[0], aceito[1], valido[0], valido[1], ocupado} !== 5'b0) begin
            n_fail++; $display("FAIL mid_async: got ac=%b%b va=%b%b oc=%b want zeros",
                               aceito[1], aceito[0], valido[1], valido[0], ocupado);
        end
        tick();
        reset = 0;
        prio_m = 0;
        tick();
        req[0] = 0;
        n_checks++;
        if ({aceito[1], aceito[0], valido[1]} !== 3'b010) begin
            n_fail++; $display("FAIL mid_regrant: got ac=%b%b va1=%b want ac=01 va1=0",
                               aceito[1], aceito[0], valido[1]);
        end
        tick();
        n_checks++;
        if ({valido[0], res_o[0]} !== {1'b1, 8'd30}) begin
            n_fail++; $display("FAIL mid_result: got va=%b res=%0d want 1 30", valido[0], res_o[0]);
        end
        pronto[0] = 1;
        tick();
        pronto[0] = 0;
        tick();
        req[1] = 0;
        n_checks++;
        if (aceito[1] !== 1'b1) begin
            n_fail++; $display("FAIL mid_loser_next: aceito1 got %b want 1", aceito[1]);
        end
        tick();
        n_checks++;
        if ({valido[1], res_o[1]} !== {1'b1, 8'h3C}) begin
            n_fail++; $display("FAIL mid_loser_res: got va=%b res=%0h want 1 3c", valido[1], res_o[1]);
        end
        pronto[1] = 1;
        tick();
        pronto[1] = 0;
        prio_m = 0;
    endtask

    task automatic test_bad_op();
        req[0] = 1; set_op(0, 8'd9, 8'd9, 3'b111);
        tick();
        req[0] = 0;
        tick();
        n_checks++;
        if ({valido[0], res_o[0], zero_o[0]} !== {1'b1, 8'd0, 1'b1}) begin
            n_fail++; $display("FAIL badop_res: got va=%b res=%0d z=%b want 1 0 1",
                               valido[0], res_o[0], zero_o[0]);
        end
        pronto[0] = 1;
        tick();
        pronto[0] = 0;
        n_checks++;
        if ({valido[0], ocupado} !== 2'b00) begin
            n_fail++; $display("FAIL badop_idle: got va=%b oc=%b want 0 0", valido[0], ocupado);
        end
        prio_m = 1;
    endtask

    task automatic test_random();
        int r, w, o, d;
        logic [8:0] exp;
        reset = 1;
        tick();
        reset = 0;
        prio_m = 0;
        res_m[0] = 0; res_m[1] = 0; zero_m[0] = 0; zero_m[1] = 0;
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(1, 3);
            req[0] = r[0]; req[1] = r[1];
            for (int i = 0; i < 2; i++)
                set_op(i, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
            w = (r == 3) ? prio_m : ((r == 2) ? 1 : 0);
            o = 1 - w;
            exp = alu_f(op_a[w], op_b[w], sinal[w]);
            tick();
            n_checks++;
            if ({aceito[w], aceito[o], alu_entrada1, alu_entrada2, alu_sinal} !==
                {2'b10, op_a[w], op_b[w], sinal[w]}) begin
                n_fail++; $display("FAIL rnd%0d_grant: got ac%0d=%b a=%0h b=%0h op=%0d want 1 %0h %0h %0d",
                                   it, w, aceito[w], alu_entrada1, alu_entrada2, alu_sinal,
                                   op_a[w], op_b[w], sinal[w]);
            end
            req[0] = 0; req[1] = 0;
            for (int i = 0; i < 2; i++) set_op(i, 8'($urandom), 8'($urandom), 3'($urandom));
            tick();
            n_checks++;
            if ({valido[w], valido[o], zero_o[w], res_o[w], res_o[o], zero_o[o]} !==
                {2'b10, exp, res_m[o], zero_m[o]}) begin
                n_fail++; $display("FAIL rnd%0d_result: got va=%b%b res%0d=%0h z=%b other=%0h want %0h z=%b other=%0h",
                                   it, valido[w], valido[o], w, res_o[w], zero_o[w], res_o[o],
                                   exp[7:0], exp[8], res_m[o]);
            end
            res_m[w] = exp[7:0]; zero_m[w] = exp[8];
            d = $urandom_range(0, 3);
            for (int i = 0; i < d; i++) begin
                pronto[o] = 1'($urandom);
                tick();
                n_checks++;
                if ({valido[w], ocupado, res_o[w]} !== {2'b11, res_m[w]}) begin
                    n_fail++; $display("FAIL rnd%0d_hold: got va=%b oc=%b res=%0h want 1 1 %0h",
                                       it, valido[w], ocupado, res_o[w], res_m[w]);
                end
            end
            pronto[w] = 1;
            tick();
            pronto[0] = 0; pronto[1] = 0;
            n_checks++;
            if ({valido[0], valido[1], ocupado} !== 3'b000) begin
                n_fail++; $display("FAIL rnd%0d_release: got va=%b%b oc=%b want 000",
                                   it, valido[1], valido[0], ocupado);
            end
            prio_m = o;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_contention();
        test_hold();
        test_reset_mid();
        test_bad_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
